round_robin_tagger: RTL
=======================

Name: round_robin_tagger

Overview:
- Upstream feeder for the tagged multiplexer stage.
- Takes one untagged data stream and assigns each element a destination tag in round-robin bursts of BURST_LEN elements.
- Optionally broadcasts end-of-stream to every tag, so each downstream multiplexer sees a last on every input.
- Output is a single registered pipeline stage with full throughput.

Parameters:
- data_t, logic[31:0], element payload type.
- NUM_TAGS, 4, number of destinations (1..2**TAG_WIDTH).
- TAG_WIDTH, 2, width of the tag field.
- BURST_LEN, 1, consecutive kept elements sent to one tag before rotating (>=1).
- LAST_BROADCAST, 1, 0: forward last on its own tag only; 1: also emit NUM_TAGS-1 dummy last elements to the remaining tags.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: asynchronous, active-high.
- in, data_i.s #(data_t), interface, input stream (data, keep, last, valid; ready driven).
- out, tagged_i.m #(data_t, TAG_WIDTH), interface, output stream (data, tag, keep, last, valid driven; ready sampled).

Behaviour:
- Reset (async assert, synchronous deassert use): out.valid=0, out.data=0, out.tag=0, out.keep=0, out.last=0, state=STREAM, cur_tag=0, burst_cnt=0, flush_cnt=0.
- Reset mid-operation discards the held output and any pending flush.
- Output register
  - load_ok = !out.valid || out.ready.
  - in.ready = load_ok && state==STREAM.
  - Latency from input handshake to out.valid is 1 cycle.
  - One element per cycle sustained when out.ready=1.
  - Output fields are held stable while out.valid && !out.ready.
- STREAM state, on input handshake:
  - keep=1, last=0: register the element with tag=cur_tag. burst_cnt++. When burst_cnt reaches BURST_LEN-1, burst_cnt returns to 0 and cur_tag = (cur_tag+1) mod NUM_TAGS, wrapping from NUM_TAGS-1 to 0 (not 2**TAG_WIDTH).
  - keep=0, last=0: consumed and dropped. No output, counters unchanged.
  - last=1, any keep: forwarded with tag=cur_tag, keep as received, last=1.
    - If LAST_BROADCAST=0 or NUM_TAGS==1: cur_tag=0, burst_cnt=0 (the next stream starts at tag 0).
    - Otherwise: latch base_tag=cur_tag, flush_cnt=1, go to FLUSH.
- FLUSH state:
  - in.ready=0.
  - When load_ok, register a dummy element: data=0, keep=0, last=1, tag=(base_tag+flush_cnt) mod NUM_TAGS; flush_cnt++.
  - After the dummy with flush_cnt==NUM_TAGS-1 is registered, set cur_tag=0, burst_cnt=0 and go to STREAM.
  - A flush of NUM_TAGS-1 dummies therefore occupies NUM_TAGS-1 loads. The first new input is accepted in the cycle after the last dummy load.
- Simultaneous events:
  - Output drain and new load in the same cycle is allowed (out.ready=1 with out.valid=1 and a new handshake).
  - Backpressure during FLUSH pauses flush_cnt; nothing is dropped or duplicated.
- Width rules:
  - Tag arithmetic uses TAG_WIDTH+1 bits before the modulo.
  - burst_cnt width is $clog2(BURST_LEN)+1.
- Elaboration errors: NUM_TAGS > 2**TAG_WIDTH, or BURST_LEN==0.

Test Plan:
- NUM_TAGS=4, BURST_LEN=1, out.ready=1: input values 10..17 kept, no last -> tags 0,1,2,3,0,1,2,3, one per cycle, each 1 cycle after its input handshake.
- BURST_LEN=3, NUM_TAGS=2: input 9 kept elements -> tags 0,0,0,1,1,1,0,0,0.
- LAST_BROADCAST=1, NUM_TAGS=4, BURST_LEN=1: inputs A,B (B last) -> out A/tag0, then B/tag1/last, then dummies keep=0 last=1 on tags 2,3,0. in.ready=0 for 3 cycles. The next input C gets tag0.
- Same as the previous case with out.ready toggling 1,0,0,1 during the flush -> each dummy is held stable while stalled, exactly 3 dummies on tags 2,3,0, no input accepted until the flush completes.
- Input keep pattern 1,0,1,0 (last=0), NUM_TAGS=4 -> only 2 outputs, tags 0,1. Then an input keep=0 last=1 -> output keep=0 last=1 on tag 2, followed by dummies on tags 3,0,1.
- Assert rst for one cycle while in FLUSH with out.valid=1 -> out.valid drops immediately (asynchronous). After release: state STREAM, the next input is tagged 0, no leftover dummies.

Source files
------------

// File: rtl/round_robin_tagger.sv
`timescale 1ns/1ps
// round_robin_tagger
//   Feeds the tagged multiplexer stage. Each kept element of one untagged stream gets a
//   destination tag; tags rotate round-robin after BURST_LEN kept elements. An element with
//   last set closes the stream. With LAST_BROADCAST the remaining tags are then each sent a
//   dummy last (keep=0, data=0), so every downstream input sees end-of-stream.
//   The output is one registered stage with full throughput.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   in_data/keep/last/valid, in_ready
//                   untagged input stream (ready driven here)
//   out_data/tag/keep/last/valid, out_ready
//                   tagged output stream (ready sampled)
module round_robin_tagger #(
   parameter type         data_t         = logic [31:0],
   parameter int unsigned NUM_TAGS       = 4,
   parameter int unsigned TAG_WIDTH      = 2,
   parameter int unsigned BURST_LEN      = 1,
   parameter int unsigned LAST_BROADCAST = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  data_t                in_data,
   input  logic                 in_keep,
   input  logic                 in_last,
   input  logic                 in_valid,
   output logic                 in_ready,
   output data_t                out_data,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic                 out_keep,
   output logic                 out_last,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned TW1 = TAG_WIDTH + 1;
   localparam int unsigned BcW = $clog2(BURST_LEN) + 1;
   localparam logic [TW1-1:0] NumTags   = TW1'(NUM_TAGS);
   localparam logic [TW1-1:0] LastFlush = TW1'(NUM_TAGS - 1);
   localparam logic [BcW-1:0] BurstMax  = BcW'(BURST_LEN - 1);
   // A single tag has nobody else to notify, so broadcast degenerates to a plain last.
   localparam bit DoFlush = (LAST_BROADCAST != 0) && (NUM_TAGS > 1);

   if (NUM_TAGS > (1 << TAG_WIDTH) || NUM_TAGS == 0) begin : g_bad_num_tags
      $error("round_robin_tagger: NUM_TAGS must be 1..2**TAG_WIDTH");
   end
   if (BURST_LEN == 0) begin : g_bad_burst_len
      $error("round_robin_tagger: BURST_LEN must be >= 1");
   end

   typedef enum logic [0:0] {StStream, StFlush} state_e;

   state_e               state_q, state_d;
   logic [TAG_WIDTH-1:0] cur_tag_q, cur_tag_d;
   logic [TAG_WIDTH-1:0] base_tag_q, base_tag_d;
   logic [BcW-1:0]       burst_cnt_q, burst_cnt_d;
   logic [TW1-1:0]       flush_cnt_q, flush_cnt_d;
   data_t                out_data_q, out_data_d;
   logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
   logic                 out_keep_q, out_keep_d;
   logic                 out_last_q, out_last_d;
   logic                 out_valid_q, out_valid_d;

   logic                 load_ok;
   logic [TW1-1:0]       tag_inc;
   logic [TAG_WIDTH-1:0] next_tag;
   logic [TW1-1:0]       flush_sum;
   logic [TW1-1:0]       flush_tag;

   // Tag arithmetic is one bit wider so the wrap compare/subtract cannot overflow.
   always_comb begin
      tag_inc   = {1'b0, cur_tag_q} + TW1'(1);
      next_tag  = (tag_inc == NumTags) ? '0 : tag_inc[TAG_WIDTH-1:0];
      flush_sum = {1'b0, base_tag_q} + flush_cnt_q;
      flush_tag = (flush_sum >= NumTags) ? (flush_sum - NumTags) : flush_sum;
   end

   always_comb begin
      state_d     = state_q;
      cur_tag_d   = cur_tag_q;
      base_tag_d  = base_tag_q;
      burst_cnt_d = burst_cnt_q;
      flush_cnt_d = flush_cnt_q;
      out_data_d  = out_data_q;
      out_tag_d   = out_tag_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;

      load_ok  = !out_valid_q || out_ready;
      in_ready = load_ok && (state_q == StStream);

      // Register drains unless something new is loaded below.
      if (load_ok) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         StStream: begin
            if (in_valid && in_ready) begin
               if (in_last) begin
                  out_valid_d = 1'b1;
                  out_data_d  = in_data;
                  out_tag_d   = cur_tag_q;
                  out_keep_d  = in_keep;
                  out_last_d  = 1'b1;
                  if (DoFlush) begin
                     base_tag_d  = cur_tag_q;
                     flush_cnt_d = TW1'(1);
                     state_d     = StFlush;
                  end else begin
                     cur_tag_d   = '0;
                     burst_cnt_d = '0;
                  end
               end else if (in_keep) begin
                  out_valid_d = 1'b1;
                  out_data_d  = in_data;
                  out_tag_d   = cur_tag_q;
                  out_keep_d  = 1'b1;
                  out_last_d  = 1'b0;
                  if (burst_cnt_q == BurstMax) begin
                     burst_cnt_d = '0;
                     cur_tag_d   = next_tag;
                  end else begin
                     burst_cnt_d = burst_cnt_q + BcW'(1);
                  end
               end
               // keep=0, last=0: consumed and dropped.
            end
         end
         StFlush: begin
            if (load_ok) begin
               out_valid_d = 1'b1;
               out_data_d  = '0;
               out_tag_d   = flush_tag[TAG_WIDTH-1:0];
               out_keep_d  = 1'b0;
               out_last_d  = 1'b1;
               if (flush_cnt_q == LastFlush) begin
                  cur_tag_d   = '0;
                  burst_cnt_d = '0;
                  state_d     = StStream;
               end else begin
                  flush_cnt_d = flush_cnt_q + TW1'(1);
               end
            end
         end
         default: state_d = StStream;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StStream;
         cur_tag_q   <= '0;
         base_tag_q  <= '0;
         burst_cnt_q <= '0;
         flush_cnt_q <= '0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
         out_keep_q  <= 1'b0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_tag_q   <= cur_tag_d;
         base_tag_q  <= base_tag_d;
         burst_cnt_q <= burst_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;
   assign out_keep  = out_keep_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;

endmodule
